// File: rtl/scratch_pad_pkg.sv
// Shared constants and types for the scratch-pad controller.
// Port-select encoding used by the arbiter and return pipeline.
package scratch_pad_pkg;

    localparam int SP_ADDR_W = 16;
    localparam int SP_DATA_W = 32;
    localparam int SP_LANES  = SP_DATA_W / 8;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_AHB,
        SEL_ENG
    } sel_e;

endpackage

// File: rtl/scratch_pad_if.sv
// Decoder-side and engine-side ports of the scratch-pad controller.
// master drives requests, slave is the controller.
interface scratch_pad_if
    import scratch_pad_pkg::*;
#(
    parameter int ADDR_W = SP_ADDR_W,
    parameter int DATA_W = SP_DATA_W
);

    logic                  ahb_en;
    logic [DATA_W/8-1:0]   ahb_wen;
    logic [31:0]           ahb_addr;
    logic [DATA_W-1:0]     ahb_wdata;
    logic [DATA_W-1:0]     ahb_rdata;

    logic                  eng_req;
    logic [DATA_W/8-1:0]   eng_we;
    logic [ADDR_W-1:0]     eng_addr;
    logic [DATA_W-1:0]     eng_wdata;
    logic                  eng_gnt;
    logic                  eng_rvalid;
    logic [DATA_W-1:0]     eng_rdata;
    logic                  eng_starve;

    modport master (
        output ahb_en, ahb_wen, ahb_addr, ahb_wdata,
        output eng_req, eng_we, eng_addr, eng_wdata,
        input  ahb_rdata, eng_gnt, eng_rvalid, eng_rdata, eng_starve
    );

    modport slave (
        input  ahb_en, ahb_wen, ahb_addr, ahb_wdata,
        input  eng_req, eng_we, eng_addr, eng_wdata,
        output ahb_rdata, eng_gnt, eng_rvalid, eng_rdata, eng_starve
    );

endinterface

// File: rtl/scratch_pad_ram.sv
// Single-port SRAM with per-byte write enables and registered read.
// Plain behavioural array so synthesis maps it onto block RAM.
module scratch_pad_ram
    import scratch_pad_pkg::*;
#(
    parameter int ADDR_W = SP_ADDR_W,
    parameter int DATA_W = SP_DATA_W
) (
    input  logic                clk,
    input  logic                en,
    input  logic [DATA_W/8-1:0] we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    // Byte-lane writes and registered read of the addressed word.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < DATA_W / 8; i++) begin
                if (we[i]) begin
                    mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/scratch_pad_ctrl.sv
// Scratch-pad controller: decoder port has fixed priority over the
// engine port; read data is routed back one cycle after the access.
module scratch_pad_ctrl
    import scratch_pad_pkg::*;
#(
    parameter int ADDR_W     = SP_ADDR_W,
    parameter int DATA_W     = SP_DATA_W,
    parameter int STARVE_MAX = 8
) (
    input  logic         PORT1HCLK,
    input  logic         PORT1HRESET,
    scratch_pad_if.slave bus
);

    localparam int LANES = DATA_W / 8;
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    sel_e              sel_d, sel_q;
    logic              rd_d, rd_q;
    logic              ram_en;
    logic [LANES-1:0]  ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] ahb_hold_d, ahb_hold_q;
    logic [DATA_W-1:0] eng_hold_d, eng_hold_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic              starve_d, starve_q;
    logic              ahb_ret, eng_ret;
    logic              unused_addr;

    assign unused_addr = ^bus.ahb_addr[31:ADDR_W];

    assign bus.eng_gnt = bus.eng_req & ~bus.ahb_en & ~PORT1HRESET;

    // Pick the winning port and steer its request onto the SRAM.
    always_comb begin
        sel_d     = SEL_NONE;
        rd_d      = 1'b0;
        ram_en    = 1'b0;
        ram_we    = '0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (!PORT1HRESET && bus.ahb_en) begin
            sel_d = SEL_AHB;
        end else if (bus.eng_gnt) begin
            sel_d = SEL_ENG;
        end
        unique case (sel_d)
            SEL_AHB: begin
                ram_en    = 1'b1;
                ram_we    = bus.ahb_wen;
                ram_addr  = bus.ahb_addr[ADDR_W-1:0];
                ram_wdata = bus.ahb_wdata;
                rd_d      = (bus.ahb_wen == '0);
            end
            SEL_ENG: begin
                ram_en    = 1'b1;
                ram_we    = bus.eng_we;
                ram_addr  = bus.eng_addr;
                ram_wdata = bus.eng_wdata;
                rd_d      = (bus.eng_we == '0);
            end
            default: ;
        endcase
    end

    scratch_pad_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (PORT1HCLK),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Route returning read data to its owner; otherwise hold the last value.
    always_comb begin
        ahb_ret    = (sel_q == SEL_AHB) && rd_q;
        eng_ret    = (sel_q == SEL_ENG) && rd_q;
        ahb_hold_d = ahb_ret ? ram_rdata : ahb_hold_q;
        eng_hold_d = eng_ret ? ram_rdata : eng_hold_q;
    end

    // Count consecutive denied engine requests, saturating at the limit.
    always_comb begin
        cnt_d = '0;
        if (bus.eng_req && !bus.eng_gnt && !PORT1HRESET) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
        starve_d = (cnt_d == CNT_MAX);
    end

    // Pipeline flags, hold registers and starvation state.
    always_ff @(posedge PORT1HCLK) begin
        if (PORT1HRESET) begin
            sel_q      <= SEL_NONE;
            rd_q       <= 1'b0;
            ahb_hold_q <= '0;
            eng_hold_q <= '0;
            cnt_q      <= '0;
            starve_q   <= 1'b0;
        end else begin
            sel_q      <= sel_d;
            rd_q       <= rd_d;
            ahb_hold_q <= ahb_hold_d;
            eng_hold_q <= eng_hold_d;
            cnt_q      <= cnt_d;
            starve_q   <= starve_d;
        end
    end

    // Reset forces every output low, squashing any in-flight return.
    assign bus.ahb_rdata  = PORT1HRESET ? '0 : ahb_hold_d;
    assign bus.eng_rdata  = PORT1HRESET ? '0 : eng_hold_d;
    assign bus.eng_rvalid = eng_ret & ~PORT1HRESET;
    assign bus.eng_starve = starve_q & ~PORT1HRESET;

endmodule

// File: tb/tb_scratch_pad_ctrl.sv
// Directed bench for scratch_pad_ctrl.
// Inputs change and outputs are sampled on the falling edge.
module tb_scratch_pad_ctrl;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    scratch_pad_if #(.ADDR_W(16), .DATA_W(32)) bus ();

    scratch_pad_ctrl #(
        .ADDR_W     (16),
        .DATA_W     (32),
        .STARVE_MAX (8)
    ) dut (
        .PORT1HCLK   (clk),
        .PORT1HRESET (rst),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.ahb_en    = 1'b0;
        bus.ahb_wen   = 4'h0;
        bus.ahb_addr  = 32'h0;
        bus.ahb_wdata = 32'h0;
        bus.eng_req   = 1'b0;
        bus.eng_we    = 4'h0;
        bus.eng_addr  = 16'h0;
        bus.eng_wdata = 32'h0;
    endtask

    task automatic ahb(input logic [3:0] wen, input logic [31:0] addr,
                       input logic [31:0] wdata);
        bus.ahb_en    = 1'b1;
        bus.ahb_wen   = wen;
        bus.ahb_addr  = addr;
        bus.ahb_wdata = wdata;
    endtask

    task automatic eng(input logic [3:0] we, input logic [15:0] addr,
                       input logic [31:0] wdata);
        bus.eng_req   = 1'b1;
        bus.eng_we    = we;
        bus.eng_addr  = addr;
        bus.eng_wdata = wdata;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        idle();
        tick();
        tick();
        bus.eng_req = 1'b1;
        #1;
        chk("rst_gnt", 32'(bus.eng_gnt), 32'h0);
        chk("rst_ahb_rdata", bus.ahb_rdata, 32'h0);
        chk("rst_rvalid", 32'(bus.eng_rvalid), 32'h0);
        chk("rst_eng_rdata", bus.eng_rdata, 32'h0);
        chk("rst_starve", 32'(bus.eng_starve), 32'h0);
        tick();
        rst = 1'b0;
        idle();
        tick();

        // full write then read back
        ahb(4'hF, 32'h10, 32'hDEADBEEF);
        tick();
        ahb(4'h0, 32'h10, 32'h0);
        tick();
        idle();
        chk("t1_read", bus.ahb_rdata, 32'hDEADBEEF);
        tick();
        chk("t1_hold", bus.ahb_rdata, 32'hDEADBEEF);

        // partial write keeps other lanes; upper address bits ignored
        ahb(4'hF, 32'h20, 32'h11223344);
        tick();
        ahb(4'b0010, 32'hFFFF_0020, 32'h0000AA00);
        tick();
        ahb(4'h0, 32'h20, 32'h0);
        tick();
        idle();
        chk("t2_partial", bus.ahb_rdata, 32'h1122AA44);
        tick();

        // engine read with decoder idle
        eng(4'h0, 16'h10, 32'h0);
        #1;
        chk("t3_gnt", 32'(bus.eng_gnt), 32'h1);
        tick();
        idle();
        chk("t3_rvalid", 32'(bus.eng_rvalid), 32'h1);
        chk("t3_rdata", bus.eng_rdata, 32'hDEADBEEF);
        chk("t3_ahb_kept", bus.ahb_rdata, 32'h1122AA44);
        tick();
        chk("t3_rvalid_pulse", 32'(bus.eng_rvalid), 32'h0);
        chk("t3_rdata_hold", bus.eng_rdata, 32'hDEADBEEF);

        // engine write: no rvalid, data visible to decoder
        eng(4'hF, 16'h50, 32'hCAFEF00D);
        #1;
        chk("ew_gnt", 32'(bus.eng_gnt), 32'h1);
        tick();
        idle();
        chk("ew_no_rvalid", 32'(bus.eng_rvalid), 32'h0);
        ahb(4'h0, 32'h50, 32'h0);
        tick();
        idle();
        chk("ew_readback", bus.ahb_rdata, 32'hCAFEF00D);
        tick();

        // collision: decoder write wins, engine read follows
        ahb(4'hF, 32'h30, 32'h5);
        eng(4'h0, 16'h30, 32'h0);
        #1;
        chk("t4_gnt_denied", 32'(bus.eng_gnt), 32'h0);
        tick();
        bus.ahb_en = 1'b0;
        #1;
        chk("t4_gnt_late", 32'(bus.eng_gnt), 32'h1);
        tick();
        idle();
        chk("t4_rvalid", 32'(bus.eng_rvalid), 32'h1);
        chk("t4_rdata", bus.eng_rdata, 32'h5);
        chk("t4_ahb_unchanged", bus.ahb_rdata, 32'hCAFEF00D);
        tick();

        // starvation under continuous decoder traffic
        ahb(4'h0, 32'h10, 32'h0);
        eng(4'h0, 16'h20, 32'h0);
        for (int k = 1; k <= 9; k++) begin
            tick();
            chk($sformatf("t5_starve_%0d", k), 32'(bus.eng_starve),
                (k >= 8) ? 32'h1 : 32'h0);
        end
        chk("t5_ahb_rdata", bus.ahb_rdata, 32'hDEADBEEF);
        bus.ahb_en = 1'b0;
        #1;
        chk("t5_gnt", 32'(bus.eng_gnt), 32'h1);
        tick();
        idle();
        chk("t5_starve_clear", 32'(bus.eng_starve), 32'h0);
        chk("t5_rvalid", 32'(bus.eng_rvalid), 32'h1);
        chk("t5_rdata", bus.eng_rdata, 32'h1122AA44);
        tick();

        // reset right after a granted engine read; write during reset dropped
        eng(4'h0, 16'h10, 32'h0);
        tick();
        idle();
        rst = 1'b1;
        ahb(4'hF, 32'h10, 32'h12345678);
        #1;
        chk("t6_rvalid", 32'(bus.eng_rvalid), 32'h0);
        chk("t6_eng_rdata", bus.eng_rdata, 32'h0);
        chk("t6_ahb_rdata", bus.ahb_rdata, 32'h0);
        chk("t6_starve", 32'(bus.eng_starve), 32'h0);
        tick();
        rst = 1'b0;
        ahb(4'h0, 32'h10, 32'h0);
        tick();
        idle();
        chk("t6_write_blocked", bus.ahb_rdata, 32'hDEADBEEF);
        chk("t6_eng_rdata_clr", bus.eng_rdata, 32'h0);
        chk("t6_rvalid_post", 32'(bus.eng_rvalid), 32'h0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
